// File: rtl/core_inst_sequencer.sv
// Instruction sequencer for the 2D accelerator core. For every kij pass it emits
// the core inst word: weight fetch, kernel load, activation fetch, execute, OFIFO drain.
module core_inst_sequencer #(
  parameter int             row    = 8,
  parameter int             col    = 8,
  parameter int             AW     = 11,
  parameter logic [AW-1:0]  W_BASE = 11'h400,
  parameter logic [AW-1:0]  X_BASE = 11'h000,
  parameter logic [AW-1:0]  P_BASE = 11'h000,
  parameter int             GAP    = 4,
  parameter int             TMO    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [3:0]    cfg_nkij,
  input  logic [AW-1:0] cfg_nnij,
  input  logic          ofifo_valid,
  output logic [33:0]   inst,
  output logic          busy,
  output logic          done,
  output logic          err_tmo,
  output logic [3:0]    kij_idx
);

  localparam int CMAX1 = ((1 << AW) > (col + 1)) ? (1 << AW) : (col + 1);
  localparam int CMAX2 = (CMAX1 > GAP) ? CMAX1 : GAP;
  localparam int CMAX  = (CMAX2 > row) ? CMAX2 : row;
  localparam int CW    = $clog2(CMAX) + 1;
  localparam int TW    = $clog2(TMO) + 1;

  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] COL_C    = CW'(col);
  localparam logic [CW-1:0] LOAD_END = CW'(col - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);
  localparam logic [TW-1:0] ZERO_T   = {TW{1'b0}};
  localparam logic [TW-1:0] ONE_T    = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TMO_END  = TW'(TMO - 1);
  localparam logic [AW-1:0] ZERO_A   = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_A    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [33:0]   IDLE_W   = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_W_FETCH, S_W_LOAD, S_W_GAP, S_X_FETCH, S_X_EXEC, S_O_DRAIN, S_DONE
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [TW-1:0] tmo_r, tmo_s;
  logic [3:0]    kij_r, kij_s, nkij_r, nkij_s;
  logic [AW-1:0] nnij_r, nnij_s, pptr_r, pptr_s;
  logic          err_r, err_s;
  logic          pend_r;
  logic          rd_s, wr_s;
  logic [33:0]   inst_r, inst_s;
  logic          busy_r, done_r;

  logic          cen_p_s, cen_x_s, l0_rd_s, l0_wr_s, exec_s, load_s;
  logic [AW-1:0] a_p_s, a_x_s;

  // Next-state, counters and drain read/write decisions
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    tmo_s   = tmo_r;
    kij_s   = kij_r;
    nkij_s  = nkij_r;
    nnij_s  = nnij_r;
    pptr_s  = pptr_r;
    err_s   = err_r;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    if (abort) begin
      state_s = S_IDLE;
      cnt_s   = ZERO_C;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            nkij_s = cfg_nkij;
            nnij_s = cfg_nnij;
            kij_s  = 4'd0;
            pptr_s = P_BASE;
            err_s  = 1'b0;
            cnt_s  = ZERO_C;
            if (cfg_nkij == 4'd0) begin
              state_s = S_DONE;
            end else begin
              state_s = S_W_FETCH;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_W_FETCH: begin
          if (cnt_r == COL_C) begin
            state_s = S_W_LOAD;
            cnt_s   = ZERO_C;
          end else begin
            cnt_s = cnt_r + ONE_C;
          end
        end
        S_W_LOAD: begin
          if (cnt_r == LOAD_END) begin
            state_s = S_W_GAP;
            cnt_s   = ZERO_C;
          end else begin
            cnt_s = cnt_r + ONE_C;
          end
        end
        S_W_GAP: begin
          if (cnt_r == GAP_END) begin
            state_s = S_X_FETCH;
            cnt_s   = ZERO_C;
          end else begin
            cnt_s = cnt_r + ONE_C;
          end
        end
        S_X_FETCH: begin
          if (cnt_r == CW'(nnij_r)) begin
            state_s = S_X_EXEC;
            cnt_s   = ZERO_C;
          end else begin
            cnt_s = cnt_r + ONE_C;
          end
        end
        S_X_EXEC: begin
          if (cnt_r + ONE_C == CW'(nnij_r)) begin
            state_s = S_O_DRAIN;
            cnt_s   = ZERO_C;
            tmo_s   = ZERO_T;
          end else begin
            cnt_s = cnt_r + ONE_C;
          end
        end
        S_O_DRAIN: begin
          // cnt_r counts words popped; a pop is always followed by its pmem write
          wr_s = pend_r;
          if (cnt_r < CW'(nnij_r)) begin
            if (ofifo_valid) begin
              rd_s  = 1'b1;
              cnt_s = cnt_r + ONE_C;
              tmo_s = ZERO_T;
            end else if (tmo_r == TMO_END) begin
              err_s   = 1'b1;
              state_s = S_DONE;
              wr_s    = 1'b0;
            end else begin
              tmo_s = tmo_r + ONE_T;
            end
          end else if (!pend_r) begin
            cnt_s = ZERO_C;
            if (kij_r + 4'd1 < nkij_r) begin
              kij_s   = kij_r + 4'd1;
              state_s = S_W_FETCH;
            end else begin
              state_s = S_DONE;
            end
          end else begin
            state_s = S_O_DRAIN;
          end
          if (wr_s) begin
            pptr_s = pptr_r + ONE_A;
          end else begin
            pptr_s = pptr_r;
          end
        end
        S_DONE: begin
          state_s = S_IDLE;
        end
        default: begin
          state_s = S_IDLE;
          cnt_s   = ZERO_C;
        end
      endcase
    end
  end

  // Instruction word for the cycle the FSM is about to enter
  always_comb begin
    cen_p_s = 1'b1;
    a_p_s   = ZERO_A;
    cen_x_s = 1'b1;
    a_x_s   = ZERO_A;
    l0_rd_s = 1'b0;
    l0_wr_s = 1'b0;
    exec_s  = 1'b0;
    load_s  = 1'b0;
    case (state_s)
      S_W_FETCH: begin
        l0_wr_s = (cnt_s != ZERO_C);
        if (cnt_s < COL_C) begin
          cen_x_s = 1'b0;
          a_x_s   = W_BASE + AW'(kij_s) * AW'(col) + cnt_s[AW-1:0];
        end else begin
          cen_x_s = 1'b1;
        end
      end
      S_W_LOAD: begin
        l0_rd_s = 1'b1;
        load_s  = 1'b1;
      end
      S_X_FETCH: begin
        l0_wr_s = (cnt_s != ZERO_C);
        if (cnt_s < CW'(nnij_s)) begin
          cen_x_s = 1'b0;
          a_x_s   = X_BASE + cnt_s[AW-1:0];
        end else begin
          cen_x_s = 1'b1;
        end
      end
      S_X_EXEC: begin
        l0_rd_s = 1'b1;
        exec_s  = 1'b1;
      end
      S_O_DRAIN: begin
        if (wr_s) begin
          cen_p_s = 1'b0;
          a_p_s   = pptr_r;
        end else begin
          cen_p_s = 1'b1;
        end
      end
      default: begin
        cen_p_s = 1'b1;
      end
    endcase
    inst_s = {1'b0, cen_p_s, cen_p_s, 11'(a_p_s), cen_x_s, 1'b1, 11'(a_x_s),
              rd_s, 1'b0, 1'b0, l0_rd_s, l0_wr_s, exec_s, load_s};
  end

  // State, run configuration and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= ZERO_C;
      tmo_r   <= ZERO_T;
      kij_r   <= 4'd0;
      nkij_r  <= 4'd0;
      nnij_r  <= ZERO_A;
      pptr_r  <= ZERO_A;
      err_r   <= 1'b0;
      pend_r  <= 1'b0;
      inst_r  <= IDLE_W;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      tmo_r   <= tmo_s;
      kij_r   <= kij_s;
      nkij_r  <= nkij_s;
      nnij_r  <= nnij_s;
      pptr_r  <= pptr_s;
      err_r   <= err_s;
      pend_r  <= rd_s;
      inst_r  <= inst_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= (state_s == S_DONE);
    end
  end

  assign inst    = inst_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err_tmo = err_r;
  assign kij_idx = kij_r;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Directed bench for core_inst_sequencer: walks the expected inst stream cycle by
// cycle for each scenario and compares every output word against a hand model.
module tb_core_inst_sequencer;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset, start, abort, ofifo_valid;
  logic [3:0]  cfg_nkij;
  logic [10:0] cfg_nnij;
  logic [33:0] inst;
  logic        busy, done, err_tmo;
  logic [3:0]  kij_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_nkij(cfg_nkij), .cfg_nnij(cfg_nnij), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .err_tmo(err_tmo), .kij_idx(kij_idx)
  );

  function automatic logic [33:0] mk(input logic pw, input logic [10:0] ap,
                                     input logic xr, input logic [10:0] ax,
                                     input logic ofr, input logic l0rd, input logic l0wr,
                                     input logic ex, input logic ld);
    logic [33:0] w;
    w = IDLE_W;
    if (pw) begin
      w[32] = 1'b0;
      w[31] = 1'b0;
      w[30:20] = ap;
    end
    if (xr) begin
      w[19] = 1'b0;
      w[17:7] = ax;
    end
    w[6] = ofr;
    w[3] = l0rd;
    w[2] = l0wr;
    w[1] = ex;
    w[0] = ld;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input int nkij, input int nnij, input int vmode, input bit exp_tmo);
    int ptr, rd_cnt, miss, dc, a;
    bit erd, ewr, nrd, nwr, v, tmo, last;
    logic [10:0] ptr_a;
    start = 1'b1;
    cfg_nkij = 4'(nkij);
    cfg_nnij = 11'(nnij);
    @(negedge clk);
    start = 1'b0;
    cfg_nkij = 4'd3;
    cfg_nnij = 11'd7;
    chk("err_cleared", 34'(err_tmo), 34'(0));
    ptr = 0;
    tmo = 1'b0;
    for (int k = 0; k < nkij && !tmo; k++) begin
      chk("kij_idx", 34'(kij_idx), 34'(k));
      for (int i = 0; i <= 8; i++) begin
        a = 1024 + k * 8 + i;
        chk("w_fetch", inst, mk(1'b0, 11'd0, i < 8, a[10:0], 1'b0, 1'b0, i > 0, 1'b0, 1'b0));
        chk("busy_run", 34'({busy, done}), 34'(2));
        @(negedge clk);
      end
      for (int i = 0; i < 8; i++) begin
        chk("w_load", inst, mk(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
        chk("w_gap", inst, IDLE_W);
        @(negedge clk);
      end
      for (int i = 0; i <= nnij; i++) begin
        a = i;
        chk("x_fetch", inst, mk(1'b0, 11'd0, i < nnij, a[10:0], 1'b0, 1'b0, i > 0, 1'b0, 1'b0));
        @(negedge clk);
      end
      for (int i = 0; i < nnij; i++) begin
        chk("x_exec", inst, mk(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        chk("busy_run", 34'({busy, done}), 34'(2));
        @(negedge clk);
      end
      erd = 1'b0; ewr = 1'b0; rd_cnt = 0; miss = 0; dc = 0;
      for (int g = 0; g < 4000; g++) begin
        ptr_a = ptr[10:0];
        chk("drain", inst, mk(ewr, ptr_a, 1'b0, 11'd0, erd, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("busy_run", 34'({busy, done}), 34'(2));
        if (ewr) ptr++;
        nwr = erd;
        last = 1'b0;
        if (rd_cnt < nnij) begin
          v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((dc % 2) == 0) : 1'b0;
          ofifo_valid = v;
          nrd = v;
          if (v) begin
            rd_cnt++;
            miss = 0;
          end else begin
            miss++;
            if (miss == TMO) begin
              tmo = 1'b1;
              last = 1'b1;
            end
          end
        end else begin
          ofifo_valid = 1'b0;
          nrd = 1'b0;
          if (!erd) last = 1'b1;
        end
        erd = nrd;
        ewr = nwr;
        dc++;
        @(negedge clk);
        if (last) break;
      end
      ofifo_valid = 1'b0;
    end
    chk("done_inst", inst, IDLE_W);
    chk("done_pulse", 34'({busy, done}), 34'(3));
    chk("err_tmo_end", 34'(err_tmo), 34'(exp_tmo));
    chk("ptr_total", 34'(ptr), 34'(tmo ? ptr : nkij * nnij));
    if (!tmo && nkij > 0) chk("kij_last", 34'(kij_idx), 34'(nkij - 1));
    @(negedge clk);
    chk("after_done", 34'({busy, done}), 34'(0));
    chk("after_inst", inst, IDLE_W);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_nkij = 4'd0; cfg_nnij = 11'd0; ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inst", inst, IDLE_W);
    chk("rst_busy", 34'(busy), 34'(0));
    chk("rst_done", 34'(done), 34'(0));
    chk("rst_err", 34'(err_tmo), 34'(0));
    chk("rst_kij", 34'(kij_idx), 34'(0));
    reset = 1'b1;
    @(negedge clk);

    run_seq(1, 5, 0, 1'b0);
    run_seq(9, 16, 0, 1'b0);
    run_seq(0, 5, 0, 1'b0);
    run_seq(2, 6, 1, 1'b0);

    run_seq(2, 5, 2, 1'b1);
    repeat (2) @(negedge clk);
    chk("err_sticky", 34'(err_tmo), 34'(1));
    run_seq(1, 5, 0, 1'b0);

    // abort in execute phase, with start raised in the same cycle
    start = 1'b1; cfg_nkij = 4'd1; cfg_nnij = 11'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (27) @(negedge clk);
    chk("pre_abort_exec", inst, mk(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_inst", inst, IDLE_W);
    chk("abort_busy", 34'({busy, done}), 34'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet", 34'({busy, done}), 34'(0));
      chk("abort_quiet_inst", inst, IDLE_W);
    end

    // reset asserted during kernel load
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_load", inst, mk(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    reset = 1'b0;
    #1;
    chk("midrst_inst", inst, IDLE_W);
    chk("midrst_busy", 34'({busy, done}), 34'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("postrst_inst", inst, IDLE_W);
    chk("postrst_busy", 34'({busy, done}), 34'(0));
    run_seq(1, 5, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
